w0rm_core_imem_responder: RTL and testbench

W0RM_CORE_IMEM_RESPONDER -- requirements
Module: w0rm_core_imem_responder

---
 rtl/w0rm_core_imem_responder.sv | 145 ++++++++++++++
 tb/tb_w0rm_core_imem_responder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/w0rm_core_imem_responder.sv
// Instruction memory responder: 32-bit word RAM read as 16-bit halfwords, fixed
// read latency, in-order first-word-fall-through response buffer with credit flow control.
module w0rm_core_imem_responder #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    INST_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h2000_0000,
  parameter int                    DEPTH_WORDS  = 1024,
  parameter int                    READ_LATENCY = 2,
  parameter int                    RESP_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  flush,
  output logic [INST_WIDTH-1:0] resp_data,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic                  resp_err,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [31:0]           wr_data
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; valid never depends on ready, and a response held under ~ready stays stable.

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int PTR_W = $clog2(RESP_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PAY_W = 1 + ADDR_WIDTH + INST_WIDTH;

  // Bounds are one bit wider than the address so BASE + size cannot wrap.
  localparam logic [ADDR_WIDTH:0] LO_BOUND = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] HI_BOUND = LO_BOUND + (ADDR_WIDTH+1)'(4 * DEPTH_WORDS);

  logic [31:0] mem_q [DEPTH_WORDS];

  // Request decode
  logic [ADDR_WIDTH:0]   req_ext;
  logic                  req_in_range;
  logic                  req_bad;
  logic [ADDR_WIDTH-1:0] req_off;
  logic [IDX_W-1:0]      req_idx;
  logic [31:0]           rd_word;
  logic [15:0]           rd_half;
  logic [INST_WIDTH-1:0] req_data;
  logic                  accept;

  assign req_ext      = {1'b0, req_addr};
  assign req_in_range = (req_ext >= LO_BOUND) && (req_ext < HI_BOUND);
  assign req_bad      = ~req_in_range | req_addr[0];
  assign req_off      = req_addr - BASE_ADDR;
  assign req_idx      = IDX_W'(req_off >> 2);
  assign rd_word      = mem_q[req_idx];
  assign rd_half      = req_addr[1] ? rd_word[31:16] : rd_word[15:0];
  assign req_data     = req_bad ? '0 : INST_WIDTH'(rd_half);
  assign accept       = req_valid && req_ready;

  // Write decode
  logic [ADDR_WIDTH:0]   wr_ext;
  logic                  wr_in_range;
  logic [ADDR_WIDTH-1:0] wr_off;
  logic [IDX_W-1:0]      wr_idx;

  assign wr_ext      = {1'b0, wr_addr};
  assign wr_in_range = (wr_ext >= LO_BOUND) && (wr_ext < HI_BOUND);
  assign wr_off      = wr_addr - BASE_ADDR;
  assign wr_idx      = IDX_W'(wr_off >> 2);

  // The read above samples the old word; this write lands at the same edge (read-first).
  always_ff @(posedge clk) begin
    if (!reset && wr_en && wr_in_range) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  // Latency pipe: stage 0 is the accepting cycle, stage READ_LATENCY-1 pushes the buffer.
  logic [READ_LATENCY-1:0]            stage_vld;
  logic [READ_LATENCY-1:0][PAY_W-1:0] stage_pay;

  assign stage_vld[0] = accept;
  assign stage_pay[0] = {req_bad, req_addr, req_data};

  if (READ_LATENCY > 1) begin : g_pipe
    logic [READ_LATENCY-2:0]            pv_q;
    logic [READ_LATENCY-2:0][PAY_W-1:0] pp_q;

    always_ff @(posedge clk) begin
      if (reset || flush) begin
        pv_q <= '0;
      end else begin
        pv_q <= stage_vld[READ_LATENCY-2:0];
      end
      pp_q <= stage_pay[READ_LATENCY-2:0];
    end

    assign stage_vld[READ_LATENCY-1:1] = pv_q;
    assign stage_pay[READ_LATENCY-1:1] = pp_q;
  end

  // Response buffer
  logic [PAY_W-1:0] buf_q [RESP_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] inflight_q;
  logic             push;
  logic             pop;
  logic [PAY_W-1:0] head;

  assign push = stage_vld[READ_LATENCY-1];
  assign pop  = resp_valid && resp_ready;
  assign head = buf_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      buf_q[wr_ptr_q] <= stage_pay[READ_LATENCY-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q    <= count_q + CNT_W'(push) - CNT_W'(pop);
      inflight_q <= inflight_q + CNT_W'(accept) - CNT_W'(push);
    end
  end

  // Credit covers both the pipe and the buffer, so a push always finds a free slot.
  assign req_ready = ~reset && ~flush &&
                     (({1'b0, inflight_q} + {1'b0, count_q}) < (CNT_W+1)'(RESP_DEPTH));

  assign resp_valid = ~reset && (count_q != '0);
  assign {resp_err, resp_addr, resp_data} = resp_valid ? head : '0;

endmodule

// File: tb/tb_w0rm_core_imem_responder.sv
// Randomized and directed bench for w0rm_core_imem_responder against a queue-based
// model: outstanding responses with due cycles plus a word-array memory image.
module tb_w0rm_core_imem_responder;

  localparam int          DEPTH = 1024;
  localparam int          LAT   = 2;
  localparam int          RD    = 4;
  localparam logic [31:0] BASE  = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] req_addr;
  logic        req_valid;
  logic        req_ready;
  logic        flush;
  logic [15:0] resp_data;
  logic [31:0] resp_addr;
  logic        resp_err;
  logic        resp_valid;
  logic        resp_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  always #5 clk = ~clk;

  w0rm_core_imem_responder #(
    .ADDR_WIDTH(32), .INST_WIDTH(16), .BASE_ADDR(BASE),
    .DEPTH_WORDS(DEPTH), .READ_LATENCY(LAT), .RESP_DEPTH(RD)
  ) dut (
    .clk(clk), .reset(reset),
    .req_addr(req_addr), .req_valid(req_valid), .req_ready(req_ready),
    .flush(flush),
    .resp_data(resp_data), .resp_addr(resp_addr), .resp_err(resp_err),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  string phase = "init";
  logic  last_acc;

  // Entry: {due cycle[80:49], err[48], addr[47:16], data[15:0]}
  logic [80:0] exp_q[$];
  logic [31:0] mem_m [DEPTH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s [%s] cyc=%0d got=%0h exp=%0h", tag, phase, cyc, got, exp);
    end
  endtask

  function automatic logic in_range(input logic [31:0] a);
    longint lo = longint'(BASE);
    longint x  = longint'(a);
    return (x >= lo) && (x < lo + 4 * DEPTH);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 4);
  endfunction

  function automatic logic [80:0] model_entry(input logic [31:0] a, input int due);
    logic [31:0] w;
    logic [15:0] d;
    logic        e;
    if (!in_range(a) || a[0]) begin
      e = 1'b1;
      d = 16'h0;
    end else begin
      e = 1'b0;
      w = mem_m[word_of(a)];
      d = a[1] ? w[31:16] : w[15:0];
    end
    return {32'(due), e, a, d};
  endfunction

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 11))
      0: return 32'h1FFF_FFFE;
      1: return 32'h2000_1000;
      2: return 32'h2000_0001 + 4 * $urandom_range(0, 15);
      3: return 32'hFFFF_FFFE;
      4: return 32'h2000_0FFC + 2 * $urandom_range(0, 1);
      default: return BASE + 4 * $urandom_range(0, 15) + 2 * $urandom_range(0, 1);
    endcase
  endfunction

  function automatic logic [31:0] pick_wr_addr();
    case ($urandom_range(0, 11))
      0: return 32'h2000_1000;
      1: return 32'h1FFF_FFFC;
      2: return 32'hFFFF_FFFC;
      default: return BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
    endcase
  endfunction

  // One clock: check outputs mid-cycle, advance the model to the coming edge.
  task automatic cycle();
    logic        exp_rdy;
    logic        exp_vld;
    logic [80:0] h;
    #3;
    exp_rdy  = !reset && !flush && (exp_q.size() < RD);
    exp_vld  = !reset && (exp_q.size() > 0) && (exp_q[0][80:49] <= 32'(cyc));
    last_acc = req_valid && req_ready;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    check("resp_valid", 64'(resp_valid), 64'(exp_vld));
    if (exp_vld) begin
      h = exp_q[0];
      check("resp_data", 64'(resp_data), 64'(h[15:0]));
      check("resp_addr", 64'(resp_addr), 64'(h[47:16]));
      check("resp_err", 64'(resp_err), 64'(h[48]));
    end
    if (reset) begin
      check("rst_data", 64'(resp_data), 64'h0);
      check("rst_addr", 64'(resp_addr), 64'h0);
      check("rst_err", 64'(resp_err), 64'h0);
    end
    if (reset || flush) begin
      exp_q.delete();
    end else begin
      if (exp_vld && resp_ready) void'(exp_q.pop_front());
      if (req_valid && exp_rdy) exp_q.push_back(model_entry(req_addr, cyc + LAT));
    end
    if (!reset && wr_en && in_range(wr_addr)) mem_m[word_of(wr_addr)] = wr_data;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    reset      = 1'b0;
    flush      = 1'b0;
    req_valid  = 1'b0;
    req_addr   = BASE;
    resp_ready = 1'b1;
    wr_en      = 1'b0;
    wr_addr    = BASE;
    wr_data    = 32'h0;
  endtask

  task automatic send(input logic [31:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    cycle();
    req_valid = 1'b0;
  endtask

  initial begin
    int n_acc;
    idle_inputs();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;

    phase = "preload";
    for (int i = 15; i >= 0; i--) begin
      wr_en   = 1'b1;
      wr_addr = BASE + 4 * i;
      wr_data = (i == 0) ? 32'hBEEF_1234 : $urandom;
      cycle();
    end
    wr_addr = BASE + 4 * (DEPTH - 1);
    wr_data = $urandom;
    cycle();
    wr_en = 1'b0;
    cycle();

    phase = "basic";
    req_valid = 1'b1;
    req_addr  = BASE;
    cycle();
    req_addr  = BASE + 2;
    cycle();
    req_valid = 1'b0;
    repeat (4) cycle();

    phase = "backpressure";
    resp_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1;
      req_addr  = BASE + 4 * i + 2 * (i % 2);
      cycle();
      n_acc += int'(last_acc);
    end
    check("burst_accepts", 64'(n_acc), 64'd4);
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    repeat (8) cycle();

    phase = "bad_addr";
    req_valid = 1'b1;
    req_addr  = 32'h1FFF_FFFE;
    cycle();
    req_addr  = 32'h2000_1000;
    cycle();
    req_addr  = 32'h2000_0001;
    cycle();
    req_addr  = 32'h2000_0FFE;
    cycle();
    req_valid = 1'b0;
    repeat (5) cycle();

    phase = "read_during_write";
    wr_en     = 1'b1;
    wr_addr   = BASE + 12;
    wr_data   = 32'hAAAA_5555;
    req_valid = 1'b1;
    req_addr  = BASE + 12;
    cycle();
    wr_en = 1'b0;
    cycle();
    req_valid = 1'b0;
    repeat (4) cycle();

    phase = "flush";
    send(BASE + 4);
    flush     = 1'b1;
    req_valid = 1'b1;
    req_addr  = BASE + 6;
    cycle();
    flush = 1'b0;
    req_addr = BASE + 8;
    cycle();
    req_valid = 1'b0;
    repeat (4) cycle();

    phase = "reset_mid";
    resp_ready = 1'b0;
    send(BASE + 16);
    send(BASE + 18);
    send(BASE + 20);
    reset   = 1'b1;
    flush   = 1'b1;
    wr_en   = 1'b1;
    wr_addr = BASE + 20;
    wr_data = $urandom;
    req_valid = 1'b1;
    cycle();
    flush = 1'b0;
    wr_en = 1'b0;
    req_valid = 1'b0;
    cycle();
    reset = 1'b0;
    resp_ready = 1'b1;
    repeat (4) cycle();
    send(BASE + 20);
    repeat (4) cycle();

    phase = "random";
    for (int i = 0; i < 800; i++) begin
      reset      = ($urandom_range(0, 199) == 0);
      flush      = ($urandom_range(0, 39) == 0);
      req_valid  = ($urandom_range(0, 3) != 0);
      req_addr   = pick_addr();
      resp_ready = ($urandom_range(0, 3) != 0);
      wr_en      = ($urandom_range(0, 7) == 0);
      wr_addr    = pick_wr_addr();
      wr_data    = $urandom;
      cycle();
    end

    phase = "drain";
    idle_inputs();
    repeat (8) cycle();
    check("drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
